oddr_tx_serializer: RTL

ODDR_TX_SERIALIZER -- requirements
Module: oddr_tx_serializer

---
 rtl/oddr_tx_pkg.sv | 13 +
 rtl/oddr_tx_hold.sv | 33 +++
 rtl/oddr_tx_serializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/oddr_tx_pkg.sv
// Shared definitions for the ODDR transmit serializer: pair width and FSM state encoding.
package oddr_tx_pkg;

    localparam int unsigned PAIR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TAIL  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/oddr_tx_hold.sv
// One-entry holding register: captures a parallel word on load, releases it on take.
module oddr_tx_hold #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_take,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    // load only happens while empty and take only while full, so they never coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/oddr_tx_serializer.sv
// Serializes parallel words into bit pairs for an O_DDR cell, framing each burst with
// a lead cycle and an output-enable tail for the tristate buffer.
module oddr_tx_serializer
    import oddr_tx_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter logic [PAIR_W-1:0]    IDLE_PAIR  = 2'b00,
    parameter int unsigned          OE_TAIL    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PAIR_W-1:0]     ddr_d,
    output logic                  ddr_en,
    output logic                  buf_oe,
    output logic                  busy,
    output logic                  burst_done
);

    localparam int unsigned NUM_PAIRS = DATA_WIDTH / PAIR_W;
    localparam int unsigned PCNT_W    = $clog2(NUM_PAIRS);
    localparam int unsigned TCNT_W    = $clog2(OE_TAIL + 1);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(NUM_PAIRS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(OE_TAIL);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

    tx_state_e             r_state;
    tx_state_e             w_state_d;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_d;
    logic [PCNT_W-1:0]     r_pair_cnt;
    logic [PCNT_W-1:0]     w_pair_cnt_d;
    logic [TCNT_W-1:0]     r_tail_cnt;
    logic [TCNT_W-1:0]     w_tail_cnt_d;

    logic [PAIR_W-1:0]     r_ddr_d;
    logic                  r_ddr_en;
    logic                  r_buf_oe;
    logic                  r_busy;
    logic                  r_burst_done;

    logic                  w_load;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_hold_data;
    logic                  w_hold_valid;

    assign in_ready = !w_hold_valid;
    assign w_load   = in_valid && in_ready;

    oddr_tx_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (in_data),
        .i_take  (w_take),
        .o_data  (w_hold_data),
        .o_valid (w_hold_valid)
    );

    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_pair_cnt_d = r_pair_cnt;
        w_tail_cnt_d = r_tail_cnt;
        w_take       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hold_valid) begin
                    w_state_d = ST_LEAD;
                end
            end
            ST_LEAD: begin
                w_state_d    = ST_SHIFT;
                w_shift_d    = w_hold_data;
                w_pair_cnt_d = '0;
                w_take       = 1'b1;
            end
            ST_SHIFT: begin
                if (r_pair_cnt == PCNT_LAST) begin
                    w_pair_cnt_d = '0;
                    if (w_hold_valid) begin
                        // next word follows the last pair with no gap
                        w_shift_d = w_hold_data;
                        w_take    = 1'b1;
                    end else begin
                        w_state_d    = ST_TAIL;
                        w_tail_cnt_d = TCNT_LOAD;
                    end
                end else begin
                    w_shift_d    = r_shift >> PAIR_W;
                    w_pair_cnt_d = r_pair_cnt + 1'b1;
                end
            end
            ST_TAIL: begin
                if (w_hold_valid) begin
                    // buffer is still driven, so resume shifting without a lead cycle
                    w_state_d    = ST_SHIFT;
                    w_shift_d    = w_hold_data;
                    w_pair_cnt_d = '0;
                    w_tail_cnt_d = '0;
                    w_take       = 1'b1;
                end else if (r_tail_cnt == TCNT_ONE) begin
                    w_state_d    = ST_IDLE;
                    w_tail_cnt_d = '0;
                end else begin
                    w_tail_cnt_d = r_tail_cnt - 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // outputs are registered from next-state values so they line up with r_state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_pair_cnt   <= '0;
            r_tail_cnt   <= '0;
            r_ddr_d      <= IDLE_PAIR;
            r_ddr_en     <= 1'b0;
            r_buf_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_shift      <= w_shift_d;
            r_pair_cnt   <= w_pair_cnt_d;
            r_tail_cnt   <= w_tail_cnt_d;
            r_ddr_d      <= (w_state_d == ST_SHIFT) ? w_shift_d[PAIR_W-1:0] : IDLE_PAIR;
            r_ddr_en     <= (w_state_d != ST_IDLE);
            r_buf_oe     <= (w_state_d != ST_IDLE);
            r_busy       <= (w_state_d != ST_IDLE);
            r_burst_done <= (r_state == ST_TAIL) && (w_state_d == ST_IDLE);
        end
    end

    assign ddr_d      = r_ddr_d;
    assign ddr_en     = r_ddr_en;
    assign buf_oe     = r_buf_oe;
    assign busy       = r_busy;
    assign burst_done = r_burst_done;

endmodule
